// File: rtl/mcp4811_rx.sv
// Receiver model of the MCP48x1 SPI DAC: oversamples the SPI pins, decodes 16-bit
// command words, implements the LDAC latch and reports the resulting output in mV.
module mcp4811_rx #(
   parameter int DAC_DATA_W = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cs_n,
   input  logic                  sck,
   input  logic                  sdi,
   input  logic                  ld_n,
   output logic [DAC_DATA_W-1:0] dac_code,
   output logic                  gain_x2,
   output logic                  active,
   output logic [12:0]           vout_mv,
   output logic                  upd,
   output logic                  frame_err
);

   localparam int PIN_CS  = 0;
   localparam int PIN_SCK = 1;
   localparam int PIN_LD  = 2;
   localparam int PIN_SDI = 3;
   localparam logic [3:0] PIN_IDLE  = 4'b0101;
   localparam int CODE_LSB = 12 - DAC_DATA_W;
   localparam int PROD_W   = DAC_DATA_W + 13;
   localparam logic [PROD_W-1:0] VOUT_MAX = PROD_W'(4095);
   localparam logic [4:0]  FRAME_BITS = 5'd16;
   localparam logic [4:0]  CNT_MAX    = 5'd31;
   localparam logic [15:0] DONT_CARE_MASK = 16'h4000 | ((16'h1 << CODE_LSB) - 16'h1);

   logic [3:0] pin_s1_q, pin_s1_d;
   logic [3:0] pin_s2_q, pin_s2_d;
   logic [3:0] pin_s3_q, pin_s3_d;
   logic [2:0] pin_prev_q, pin_prev_d;

   logic [15:0] shift_q, shift_d;
   logic [4:0]  bit_cnt_q, bit_cnt_d;
   logic [DAC_DATA_W-1:0] in_code_q, in_code_d;
   logic in_ga_q, in_ga_d;
   logic in_shdn_q, in_shdn_d;
   logic xfer_pend_q, xfer_pend_d;

   logic [DAC_DATA_W-1:0] dac_code_q, dac_code_d;
   logic gain_x2_q, gain_x2_d;
   logic active_q, active_d;
   logic upd_q, upd_d;
   logic frame_err_q, frame_err_d;

   logic cs_lvl, cs_rise, cs_fall, sck_rise, ld_lvl, ld_fall, sdi_smp;
   logic frame_load, xfer_now;
   logic [PROD_W-1:0] prod, scaled;
   logic dont_care_unused;

   // Stage 3 is the last synchronized copy; pin_prev holds it one cycle older for edges.
   always_comb begin
      pin_s1_d   = {sdi, ld_n, sck, cs_n};
      pin_s2_d   = pin_s1_q;
      pin_s3_d   = pin_s2_q;
      pin_prev_d = pin_s3_q[2:0];
   end

   assign cs_lvl   = pin_s3_q[PIN_CS];
   assign cs_rise  =  cs_lvl & ~pin_prev_q[PIN_CS];
   assign cs_fall  = ~cs_lvl &  pin_prev_q[PIN_CS];
   assign sck_rise =  pin_s3_q[PIN_SCK] & ~pin_prev_q[PIN_SCK];
   assign ld_lvl   = pin_s3_q[PIN_LD];
   assign ld_fall  = ~ld_lvl &  pin_prev_q[PIN_LD];
   assign sdi_smp  = pin_s3_q[PIN_SDI];

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      in_code_d   = in_code_q;
      in_ga_d     = in_ga_q;
      in_shdn_d   = in_shdn_q;
      xfer_pend_d = 1'b0;
      dac_code_d  = dac_code_q;
      gain_x2_d   = gain_x2_q;
      active_d    = active_q;
      upd_d       = 1'b0;
      frame_err_d = 1'b0;
      frame_load  = 1'b0;
      xfer_now    = 1'b0;

      if (cs_fall) bit_cnt_d = '0;
      if (sck_rise && !cs_lvl) begin
         shift_d = {shift_q[14:0], sdi_smp};
         if (bit_cnt_d != CNT_MAX) bit_cnt_d = bit_cnt_d + 5'd1;
      end

      if (cs_rise) begin
         if (bit_cnt_q != FRAME_BITS) begin
            frame_err_d = 1'b1;
         end else if (!shift_q[15]) begin
            in_code_d  = shift_q[11:CODE_LSB];
            in_ga_d    = shift_q[13];
            in_shdn_d  = shift_q[12];
            frame_load = 1'b1;
         end
      end

      // A load and an LDAC fall in the same cycle: load now, transfer next cycle, one pulse.
      if (ld_fall && cs_lvl) begin
         if (cs_rise) xfer_pend_d = 1'b1;
         else         xfer_now    = 1'b1;
      end else if (frame_load && !ld_lvl) begin
         xfer_now = 1'b1;
      end
      if (xfer_pend_q) xfer_now = 1'b1;

      if (xfer_now) begin
         dac_code_d = in_code_d;
         gain_x2_d  = ~in_ga_d;
         active_d   = in_shdn_d;
         upd_d      = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: every flop here is reset, including the synchronizers, so the pins start idle.
      if (!rst_n) begin
         pin_s1_q    <= PIN_IDLE;
         pin_s2_q    <= PIN_IDLE;
         pin_s3_q    <= PIN_IDLE;
         pin_prev_q  <= PIN_IDLE[2:0];
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         in_code_q   <= '0;
         in_ga_q     <= 1'b1;
         in_shdn_q   <= 1'b0;
         xfer_pend_q <= 1'b0;
         dac_code_q  <= '0;
         gain_x2_q   <= 1'b0;
         active_q    <= 1'b0;
         upd_q       <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so all state updates together at the edge.
         pin_s1_q    <= pin_s1_d;
         pin_s2_q    <= pin_s2_d;
         pin_s3_q    <= pin_s3_d;
         pin_prev_q  <= pin_prev_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         in_code_q   <= in_code_d;
         in_ga_q     <= in_ga_d;
         in_shdn_q   <= in_shdn_d;
         xfer_pend_q <= xfer_pend_d;
         dac_code_q  <= dac_code_d;
         gain_x2_q   <= gain_x2_d;
         active_q    <= active_d;
         upd_q       <= upd_d;
         frame_err_q <= frame_err_d;
      end
   end

   // vout = code * G * 2048 / 2^W, clipped at the 4.095 V ceiling of 2x gain.
   always_comb begin
      prod   = PROD_W'(dac_code_q) << (gain_x2_q ? 12 : 11);
      scaled = prod >> DAC_DATA_W;
      if (!active_q)              vout_mv = '0;
      else if (scaled > VOUT_MAX) vout_mv = 13'd4095;
      else                        vout_mv = 13'(scaled);
   end

   assign dont_care_unused = ^(shift_q & DONT_CARE_MASK);

   assign dac_code  = dac_code_q;
   assign gain_x2   = gain_x2_q;
   assign active    = active_q;
   assign upd       = upd_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_mcp4811_rx.sv
// Randomized self-checking bench for mcp4811_rx: drives SPI frames and LDAC,
// compares against a word-level model of the DAC input register and output latch.
`timescale 1ns/1ps
module tb_mcp4811_rx;

   localparam int W        = 10;
   localparam int SCK_HALF = 12;

   logic clk = 1'b0, rst_n = 1'b0, cs_n = 1'b1, sck = 1'b0, sdi = 1'b0, ld_n = 1'b1;
   logic [W-1:0] dac_code;
   logic gain_x2, active, upd, frame_err;
   logic [12:0] vout_mv;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: input register (m_*) and visible output latch (o_*)
   int m_code, m_ga, m_shdn;
   int o_code, o_gain2, o_active;

   mcp4811_rx #(.DAC_DATA_W(W)) dut (
      .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .sck(sck), .sdi(sdi), .ld_n(ld_n),
      .dac_code(dac_code), .gain_x2(gain_x2), .active(active), .vout_mv(vout_mv),
      .upd(upd), .frame_err(frame_err)
   );

   always #21 clk = ~clk;

   function automatic int exp_vout();
      int v;
      if (o_active == 0) return 0;
      v = o_code * (o_gain2 != 0 ? 2 : 1) * 2048 / (1 << W);
      return (v > 4095) ? 4095 : v;
   endfunction

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic model_reset();
      m_code = 0; m_ga = 1; m_shdn = 0;
      o_code = 0; o_gain2 = 0; o_active = 0;
   endtask

   // Shift nbits of value MSB first, end the frame, and check the outcome against the model.
   task automatic do_frame(input logic [31:0] value, input int nbits, input bit drop_ld, input string tag);
      int upd_seen = 0, err_seen = 0, lat = -1, exp_lat;
      int word;
      bit valid, exp_upd, ld_low_before;
      ld_low_before = (ld_n == 1'b0);
      @(negedge clk);
      cs_n = 1'b0;
      wait_clk(SCK_HALF);
      for (int i = nbits - 1; i >= 0; i--) begin
         sdi = value[i];
         wait_clk(SCK_HALF);
         sck = 1'b1;
         wait_clk(SCK_HALF);
         sck = 1'b0;
      end
      wait_clk(SCK_HALF);
      cs_n = 1'b1;
      if (drop_ld) ld_n = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (upd === 1'b1) begin
            upd_seen++;
            if (lat < 0) lat = c;
         end
         if (frame_err === 1'b1) err_seen++;
      end

      word  = int'(value & 32'hFFFF);
      valid = (nbits == 16) && ((word / 32768) == 0);
      if (valid) begin
         m_code = (word / (1 << (12 - W))) % (1 << W);
         m_ga   = (word / 8192) % 2;
         m_shdn = (word / 4096) % 2;
      end
      exp_upd = (valid && ld_low_before) || drop_ld;
      exp_lat = drop_ld ? 5 : 4;
      if (exp_upd) begin
         o_code = m_code; o_gain2 = 1 - m_ga; o_active = m_shdn;
      end

      n_checks++;
      if (err_seen != ((nbits != 16) ? 1 : 0)) begin
         n_fail++;
         $display("FAIL %s frame_err pulses: got %0d expected %0d", tag, err_seen, (nbits != 16) ? 1 : 0);
      end
      n_checks++;
      if (upd_seen != int'(exp_upd)) begin
         n_fail++;
         $display("FAIL %s upd pulses: got %0d expected %0d", tag, upd_seen, int'(exp_upd));
      end
      if (exp_upd) begin
         n_checks++;
         if (lat != exp_lat) begin
            n_fail++;
            $display("FAIL %s upd latency: got %0d expected %0d", tag, lat, exp_lat);
         end
      end
      n_checks += 4;
      if (dac_code !== W'(o_code)) begin
         n_fail++; $display("FAIL %s dac_code: got %0d expected %0d", tag, dac_code, o_code);
      end
      if (gain_x2 !== 1'(o_gain2)) begin
         n_fail++; $display("FAIL %s gain_x2: got %0b expected %0d", tag, gain_x2, o_gain2);
      end
      if (active !== 1'(o_active)) begin
         n_fail++; $display("FAIL %s active: got %0b expected %0d", tag, active, o_active);
      end
      if (vout_mv !== 13'(exp_vout())) begin
         n_fail++; $display("FAIL %s vout_mv: got %0d expected %0d", tag, vout_mv, exp_vout());
      end
   endtask

   // Pull LDAC low with CS high: the input register must be transferred 4 cycles later.
   task automatic do_ld_fall(input string tag);
      int upd_seen = 0, lat = -1;
      @(negedge clk);
      ld_n = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (upd === 1'b1) begin
            upd_seen++;
            if (lat < 0) lat = c;
         end
      end
      o_code = m_code; o_gain2 = 1 - m_ga; o_active = m_shdn;
      n_checks += 2;
      if (upd_seen != 1) begin
         n_fail++; $display("FAIL %s upd pulses: got %0d expected 1", tag, upd_seen);
      end
      if (lat != 4) begin
         n_fail++; $display("FAIL %s upd latency: got %0d expected 4", tag, lat);
      end
      n_checks += 4;
      if (dac_code !== W'(o_code)) begin
         n_fail++; $display("FAIL %s dac_code: got %0d expected %0d", tag, dac_code, o_code);
      end
      if (gain_x2 !== 1'(o_gain2)) begin
         n_fail++; $display("FAIL %s gain_x2: got %0b expected %0d", tag, gain_x2, o_gain2);
      end
      if (active !== 1'(o_active)) begin
         n_fail++; $display("FAIL %s active: got %0b expected %0d", tag, active, o_active);
      end
      if (vout_mv !== 13'(exp_vout())) begin
         n_fail++; $display("FAIL %s vout_mv: got %0d expected %0d", tag, vout_mv, exp_vout());
      end
   endtask

   task automatic set_ld_high();
      @(negedge clk);
      ld_n = 1'b1;
      wait_clk(6);
   endtask

   task automatic test_reset();
      model_reset();
      wait_clk(3);
      n_checks += 6;
      if (dac_code !== '0)     begin n_fail++; $display("FAIL reset dac_code: got %0d expected 0", dac_code); end
      if (gain_x2 !== 1'b0)    begin n_fail++; $display("FAIL reset gain_x2: got %0b expected 0", gain_x2); end
      if (active !== 1'b0)     begin n_fail++; $display("FAIL reset active: got %0b expected 0", active); end
      if (vout_mv !== '0)      begin n_fail++; $display("FAIL reset vout_mv: got %0d expected 0", vout_mv); end
      if (upd !== 1'b0)        begin n_fail++; $display("FAIL reset upd: got %0b expected 0", upd); end
      if (frame_err !== 1'b0)  begin n_fail++; $display("FAIL reset frame_err: got %0b expected 0", frame_err); end
      @(negedge clk);
      rst_n = 1'b1;
      wait_clk(5);
   endtask

   task automatic test_direct_load();
      do_ld_fall("ld_after_reset");
      do_frame(32'h3640, 16, 1'b0, "w3640");
      n_checks += 2;
      if (dac_code !== W'(400)) begin n_fail++; $display("FAIL w3640 code: got %0d expected 400", dac_code); end
      if (vout_mv !== 13'd800)  begin n_fail++; $display("FAIL w3640 mv: got %0d expected 800", vout_mv); end
      do_frame(32'h1640, 16, 1'b0, "w1640");
      n_checks++;
      if (vout_mv !== 13'd1600) begin n_fail++; $display("FAIL w1640 mv: got %0d expected 1600", vout_mv); end
      do_frame(32'h1FFC, 16, 1'b0, "w1ffc");
      n_checks += 2;
      if (dac_code !== W'(1023)) begin n_fail++; $display("FAIL w1ffc code: got %0d expected 1023", dac_code); end
      if (vout_mv !== 13'd4092)  begin n_fail++; $display("FAIL w1ffc mv: got %0d expected 4092", vout_mv); end
      do_frame(32'h2640, 16, 1'b0, "w2640_shdn");
      n_checks++;
      if (vout_mv !== 13'd0) begin n_fail++; $display("FAIL w2640 mv: got %0d expected 0", vout_mv); end
   endtask

   task automatic test_other_device();
      do_frame(32'hB640, 16, 1'b0, "wb640_ignored");
   endtask

   task automatic test_ldac_held();
      set_ld_high();
      do_frame(32'h3190, 16, 1'b0, "w3190_held");
      do_ld_fall("ld_release_3190");
      n_checks += 2;
      if (dac_code !== W'(100)) begin n_fail++; $display("FAIL ld3190 code: got %0d expected 100", dac_code); end
      if (vout_mv !== 13'd200)  begin n_fail++; $display("FAIL ld3190 mv: got %0d expected 200", vout_mv); end
   endtask

   task automatic test_frame_errors();
      do_frame(32'h0000_0640, 12, 1'b0, "short12");
      do_frame(32'h0001_3AB0, 17, 1'b0, "long17");
   endtask

   task automatic test_simultaneous();
      set_ld_high();
      do_frame(32'h3800, 16, 1'b1, "cs_rise_ld_fall");
   endtask

   task automatic test_random();
      logic [31:0] value;
      int nbits;
      for (int k = 0; k < 24; k++) begin
         if ($urandom_range(0, 1) == 0) begin
            if (ld_n == 1'b1) do_ld_fall("rand_ld_fall");
         end else if (ld_n == 1'b0) begin
            set_ld_high();
         end
         nbits = ($urandom_range(0, 5) == 0) ? int'($urandom_range(12, 20)) : 16;
         value = $urandom;
         if ($urandom_range(0, 3) != 0) value[15] = 1'b0;
         do_frame(value, nbits, 1'b0, "rand_frame");
      end
   endtask

   task automatic test_reset_midframe();
      if (ld_n == 1'b1) do_ld_fall("pre_rst_ld");
      do_frame(32'h3640, 16, 1'b0, "pre_rst_frame");
      @(negedge clk);
      cs_n = 1'b0;
      wait_clk(SCK_HALF);
      for (int i = 0; i < 5; i++) begin
         sdi = i[0];
         wait_clk(SCK_HALF);
         sck = 1'b1;
         wait_clk(SCK_HALF);
         sck = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      n_checks += 4;
      if (dac_code !== '0)  begin n_fail++; $display("FAIL midrst dac_code: got %0d expected 0", dac_code); end
      if (gain_x2 !== 1'b0) begin n_fail++; $display("FAIL midrst gain_x2: got %0b expected 0", gain_x2); end
      if (active !== 1'b0)  begin n_fail++; $display("FAIL midrst active: got %0b expected 0", active); end
      if (vout_mv !== '0)   begin n_fail++; $display("FAIL midrst vout_mv: got %0d expected 0", vout_mv); end
      cs_n = 1'b1; sck = 1'b0; ld_n = 1'b1;
      model_reset();
      wait_clk(3);
      rst_n = 1'b1;
      wait_clk(5);
      do_ld_fall("post_rst_ld");
      do_frame(32'h1FFC, 16, 1'b0, "post_rst_frame");
   endtask

   initial begin
      test_reset();
      test_direct_load();
      test_other_device();
      test_ldac_held();
      test_frame_errors();
      test_simultaneous();
      test_random();
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
